// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-requester memory port arbiter: FSM states, op encoding
// and default bus widths.
package mem_port_arbiter_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE_D = 3'd1,
      ISSUE_F = 3'd2,
      WAIT_D  = 3'd3,
      WAIT_F  = 3'd4
   } arb_state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } mem_op_e;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Wait-cycle counter for an outstanding memory op; expired rises once
// TIMEOUT-1 cycles have been counted since the last clear.
module arb_timeout_ctr #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   // Hold at the expiry value so the flag stays stable until the next clear.
   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en && !expired)
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expired = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one Stall/Done memory port between fetch and data requesters.
// Data has priority; a saturating streak counter forces fetch in after MAX_STREAK data grants.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int MAX_STREAK = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              f_rd,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_stall,
   output logic              f_done,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              d_rd,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_stall,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_done,
   output logic              err
);

   localparam int SW = $clog2(MAX_STREAK + 1);

   arb_state_e        state_q, state_d;
   mem_op_e           op_q, op_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              err_q, err_d;
   logic [SW-1:0]     streak_q, streak_d;

   logic d_req, illegal, force_f, grant_d, grant_f;
   logic in_issue, in_wait, expired, finish, tmo;

   assign d_req    = d_rd | d_wr;
   assign illegal  = d_rd & d_wr;
   assign force_f  = f_rd && (streak_q >= SW'(MAX_STREAK));
   assign grant_d  = (state_q == IDLE) && !illegal && d_req && !force_f;
   assign grant_f  = (state_q == IDLE) && !illegal && f_rd && !grant_d;
   assign in_issue = (state_q == ISSUE_D) || (state_q == ISSUE_F);
   assign in_wait  = (state_q == WAIT_D) || (state_q == WAIT_F);
   assign finish   = in_wait && (mem_done || expired);
   assign tmo      = in_wait && !mem_done && expired;

   arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (in_issue),
      .en      (in_wait),
      .expired (expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_d)
               state_d = ISSUE_D;
            else if (grant_f)
               state_d = ISSUE_F;
         end
         ISSUE_D: state_d = WAIT_D;
         ISSUE_F: state_d = WAIT_F;
         WAIT_D, WAIT_F: begin
            if (finish)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Read data is passed straight through on done; a timeout returns zero instead.
   always_comb begin
      mem_rd  = in_issue && (op_q == OP_RD);
      mem_wr  = in_issue && (op_q == OP_WR);
      f_done  = finish && (state_q == WAIT_F);
      d_done  = finish && (state_q == WAIT_D);
      f_rdata = f_rdata_q;
      d_rdata = d_rdata_q;
      if (f_done)
         f_rdata = tmo ? '0 : mem_rdata;
      if (d_done)
         d_rdata = tmo ? '0 : mem_rdata;
      err     = err_q || tmo;
      f_stall = f_rd && !f_done;
      d_stall = d_req && !d_done;
   end

   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   always_comb begin
      op_d        = op_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      f_rdata_d   = f_rdata;
      d_rdata_d   = d_rdata;
      err_d       = (state_q == IDLE) && illegal;
      streak_d    = streak_q;
      if (grant_d) begin
         op_d       = d_wr ? OP_WR : OP_RD;
         mem_addr_d = d_addr;
         if (d_wr)
            mem_wdata_d = d_wdata;
      end else if (grant_f) begin
         op_d       = OP_RD;
         mem_addr_d = f_addr;
      end
      // The streak only measures data grants taken while fetch is actually waiting.
      if (!f_rd || grant_f)
         streak_d = '0;
      else if (grant_d && (streak_q < SW'(MAX_STREAK)))
         streak_d = streak_q + SW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q        <= OP_RD;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         f_rdata_q   <= '0;
         d_rdata_q   <= '0;
         err_q       <= 1'b0;
         streak_q    <= '0;
      end else begin
         op_q        <= op_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         f_rdata_q   <= f_rdata_d;
         d_rdata_q   <= d_rdata_d;
         err_q       <= err_d;
         streak_q    <= streak_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

   localparam int AW   = 16;
   localparam int DW   = 16;
   localparam int MAXS = 4;
   localparam int TMO  = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          f_rd, f_stall, f_done;
   logic [AW-1:0] f_addr;
   logic [DW-1:0] f_rdata;
   logic          d_rd, d_wr, d_stall, d_done;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata, d_rdata;
   logic          mem_rd, mem_wr, mem_done, err;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MAXS), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .f_rd(f_rd), .f_addr(f_addr), .f_stall(f_stall), .f_done(f_done), .f_rdata(f_rdata),
      .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_stall(d_stall), .d_done(d_done), .d_rdata(d_rdata),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Transaction-level model: one outstanding transaction, a free-from cycle and a streak count.
   bit            txnValid = 0, txnIsD = 0, txnWr = 0, txnTmo = 0;
   logic [15:0]   txnAddr = 0, txnWdata = 0;
   int            issueCyc = -1, doneCyc = -1, freeAt = 0, streak = 0, errAt = -1;
   logic [15:0]   expFR = 0, expDR = 0;
   int            latMode = 0, pend = 0;
   logic [15:0]   memArr [logic [15:0]];
   int            fGrants = 0, dGrants = 0;
   bit            prevFDone = 0, prevDDone = 0;

   int            fMode = 0, dMode = 0;
   logic [15:0]   fAddrFix = 0, dAddrFix = 0, dDataFix = 0;
   bit            dWrFix = 0;

   byte           obsOp[$];
   logic [15:0]   obsAddr[$];
   logic [15:0]   obsWdata[$];
   int            obsIssueCyc[$];
   int            obsErrCyc[$];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic clearObs();
      obsOp.delete(); obsAddr.delete(); obsWdata.delete();
      obsIssueCyc.delete(); obsErrCyc.delete();
   endtask

   // Requester agents: 0 off, 1 random, 2 hold, 3 one-shot, 4 (data) one illegal cycle.
   task automatic applyStimulus();
      bit go, w;
      case (fMode)
         0: f_rd = 1'b0;
         1: if (prevFDone || !f_rd) begin
               f_rd   = ($urandom_range(0, 2) != 0);
               f_addr = 16'h0100 + 16'($urandom_range(0, 7) * 2);
            end
         2: begin f_rd = 1'b1; f_addr = fAddrFix; end
         3: if (prevFDone) begin f_rd = 1'b0; fMode = 0; end
            else begin f_rd = 1'b1; f_addr = fAddrFix; end
         default: f_rd = 1'b0;
      endcase
      case (dMode)
         0: begin d_rd = 1'b0; d_wr = 1'b0; end
         1: if (prevDDone || !(d_rd || d_wr)) begin
               go      = ($urandom_range(0, 2) != 0);
               w       = 1'($urandom_range(0, 1));
               d_rd    = go && !w;
               d_wr    = go && w;
               d_addr  = 16'h2000 + 16'($urandom_range(0, 7) * 2);
               d_wdata = 16'($urandom);
            end
         2: begin d_rd = !dWrFix; d_wr = dWrFix; d_addr = dAddrFix; d_wdata = dDataFix; end
         3: if (prevDDone) begin d_rd = 1'b0; d_wr = 1'b0; dMode = 0; end
            else begin d_rd = !dWrFix; d_wr = dWrFix; d_addr = dAddrFix; d_wdata = dDataFix; end
         4: begin d_rd = 1'b1; d_wr = 1'b1; dMode = 0; end
         default: begin d_rd = 1'b0; d_wr = 1'b0; end
      endcase
   endtask

   // One clock cycle: drive requests and memory, predict, compare, advance.
   task automatic runCycle();
      bit errNow, isDone, issueNow, expFDone, expDDone;
      int lat;
      logic [15:0] rdVal;
      errNow = (errAt == cyc);
      applyStimulus();
      if (!f_rd) streak = 0;

      mem_done  = 1'b0;
      mem_rdata = 16'($urandom);
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            mem_done = 1'b1;
            if (!txnWr) mem_rdata = memArr.exists(txnAddr) ? memArr[txnAddr] : ~txnAddr;
         end
      end
      issueNow = txnValid && (cyc == issueCyc);
      if (issueNow) begin
         // A completion strobe in the issue cycle must be ignored by the arbiter.
         mem_done = 1'($urandom_range(0, 1));
         if (latMode < 0) begin
            pend = -1; doneCyc = cyc + TMO; txnTmo = 1;
         end else begin
            lat = (latMode > 0) ? latMode : $urandom_range(1, 4);
            pend = lat; doneCyc = cyc + lat; txnTmo = 0;
         end
      end

      if (!txnValid && cyc >= freeAt) begin
         if (d_rd && d_wr) begin
            errAt = cyc + 1;
         end else if ((d_rd || d_wr) && !(f_rd && streak >= MAXS)) begin
            txnValid = 1; txnIsD = 1; txnWr = d_wr; txnAddr = d_addr; txnWdata = d_wdata;
            issueCyc = cyc + 1; doneCyc = -1; dGrants++;
            if (f_rd) streak++;
         end else if (f_rd) begin
            txnValid = 1; txnIsD = 0; txnWr = 0; txnAddr = f_addr;
            issueCyc = cyc + 1; doneCyc = -1; fGrants++; streak = 0;
         end
      end

      #1;
      isDone   = txnValid && (cyc == doneCyc);
      expFDone = isDone && !txnIsD;
      expDDone = isDone && txnIsD;
      if (isDone) begin
         rdVal = txnTmo ? 16'h0 : mem_rdata;
         if (txnIsD) expDR = rdVal; else expFR = rdVal;
      end
      checkOutput("mem_rd", mem_rd, issueNow && !txnWr);
      checkOutput("mem_wr", mem_wr, issueNow && txnWr);
      if (issueNow) begin
         checkOutput("mem_addr", mem_addr, txnAddr);
         if (txnWr) checkOutput("mem_wdata", mem_wdata, txnWdata);
      end
      checkOutput("f_done", f_done, expFDone);
      checkOutput("d_done", d_done, expDDone);
      checkOutput("f_rdata", f_rdata, expFR);
      checkOutput("d_rdata", d_rdata, expDR);
      checkOutput("err", err, errNow || (isDone && txnTmo));
      checkOutput("f_stall", f_stall, f_rd && !expFDone);
      checkOutput("d_stall", d_stall, (d_rd || d_wr) && !expDDone);

      if (mem_rd || mem_wr) begin
         obsOp.push_back(mem_wr ? 8'd87 : 8'd82);
         obsAddr.push_back(mem_addr);
         obsWdata.push_back(mem_wdata);
         obsIssueCyc.push_back(cyc);
      end
      if (err) obsErrCyc.push_back(cyc);
      if (isDone) begin
         if (txnWr && !txnTmo) memArr[txnAddr] = txnWdata;
         txnValid = 0;
         freeAt   = cyc + 1;
      end
      prevFDone = expFDone;
      prevDDone = expDDone;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic runUntilIdle(input int budget, input string tag);
      int n;
      n = 0;
      while ((txnValid || fMode != 0 || dMode != 0 || f_rd || d_rd || d_wr) && n < budget) begin
         runCycle();
         n++;
      end
      checkOutput({tag, "_budget"}, n < budget, 1);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_mem_rd"}, mem_rd, 0);
      checkOutput({tag, "_mem_wr"}, mem_wr, 0);
      checkOutput({tag, "_mem_addr"}, mem_addr, 0);
      checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
      checkOutput({tag, "_f_done"}, f_done, 0);
      checkOutput({tag, "_d_done"}, d_done, 0);
      checkOutput({tag, "_f_rdata"}, f_rdata, 0);
      checkOutput({tag, "_d_rdata"}, d_rdata, 0);
      checkOutput({tag, "_err"}, err, 0);
   endtask

   // Reset asserted mid-cycle, away from the clock edge; the model abandons its transaction.
   task automatic asyncReset();
      #2;
      rst = 1'b1; f_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0; mem_done = 1'b0;
      #1;
      checkResetOutputs("midRst");
      @(posedge clk);
      #1;
      checkOutput("midRst_d_done_hold", d_done, 0);
      rst = 1'b0;
      txnValid = 0; pend = 0; streak = 0; errAt = -1; expFR = 0; expDR = 0;
      prevFDone = 0; prevDDone = 0; fMode = 0; dMode = 0;
      cyc++;
      freeAt = cyc;
   endtask

   initial begin
      int n, d0;
      string expSeq;
      rst = 1'b1; f_rd = 0; f_addr = 0; d_rd = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
      mem_rdata = 0; mem_done = 0;
      @(posedge clk);
      #1;
      checkResetOutputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) runCycle();

      $display("[TB] fetch alone at 0x0040, latency 3");
      clearObs(); latMode = 3; fAddrFix = 16'h0040; fMode = 3;
      runUntilIdle(20, "fetchAlone");
      checkOutput("fetchAlone_issues", obsOp.size(), 1);
      if (obsOp.size() > 0) checkOutput("fetchAlone_addr", obsAddr[0], 16'h0040);

      $display("[TB] simultaneous data read and fetch");
      clearObs(); latMode = 0;
      dAddrFix = 16'h1000; dWrFix = 0; dMode = 3;
      fAddrFix = 16'h0002; fMode = 3;
      runUntilIdle(40, "contend");
      checkOutput("contend_issues", obsOp.size(), 2);
      if (obsOp.size() >= 2) begin
         checkOutput("contend_first", obsAddr[0], 16'h1000);
         checkOutput("contend_second", obsAddr[1], 16'h0002);
      end

      $display("[TB] held data writes against held fetch");
      clearObs(); dAddrFix = 16'h3000; dWrFix = 1; dDataFix = 16'($urandom); dMode = 2;
      fAddrFix = 16'h0080; fMode = 2;
      d0 = dGrants; n = 0;
      while (!((dGrants - d0) >= 6 && !txnValid) && n < 300) begin
         runCycle();
         n++;
      end
      checkOutput("streak_budget", n < 300, 1);
      dMode = 0; fMode = 0;
      runUntilIdle(40, "streakDrain");
      expSeq = "WWWWRWW";
      checkOutput("streak_issues", obsOp.size(), 7);
      for (int i = 0; i < 7; i++)
         if (i < obsOp.size()) checkOutput($sformatf("streak_op%0d", i), obsOp[i], expSeq[i]);

      $display("[TB] memory never completes");
      clearObs(); latMode = -1; dAddrFix = 16'(($urandom_range(0, 255)) * 2); dWrFix = 0; dMode = 3;
      runUntilIdle(100, "timeout");
      checkOutput("timeout_issues", obsIssueCyc.size(), 1);
      checkOutput("timeout_errs", obsErrCyc.size(), 1);
      if (obsIssueCyc.size() == 1 && obsErrCyc.size() == 1)
         checkOutput("timeout_delay", obsErrCyc[0] - obsIssueCyc[0], TMO);
      clearObs(); latMode = 0; fAddrFix = 16'h0044; fMode = 3;
      runUntilIdle(20, "afterTimeout");
      checkOutput("afterTimeout_issues", obsOp.size(), 1);

      $display("[TB] illegal read+write");
      clearObs(); dMode = 4;
      repeat (4) runCycle();
      checkOutput("illegal_issues", obsOp.size(), 0);
      checkOutput("illegal_errs", obsErrCyc.size(), 1);

      $display("[TB] reset during data wait");
      clearObs(); latMode = 10; dAddrFix = 16'h1234; dWrFix = 0; dMode = 3;
      n = 0;
      while (!(txnValid && cyc >= issueCyc + 2) && n < 20) begin
         runCycle();
         n++;
      end
      checkOutput("midRst_reach_wait", n < 20, 1);
      asyncReset();
      latMode = 0;
      repeat (3) runCycle();
      clearObs(); fAddrFix = 16'h0046; fMode = 3;
      runUntilIdle(20, "afterReset");
      checkOutput("afterReset_issues", obsOp.size(), 1);

      $display("[TB] data write 0xBEEF at 0x2002");
      clearObs(); dAddrFix = 16'h2002; dDataFix = 16'hBEEF; dWrFix = 1; dMode = 3;
      runUntilIdle(20, "write");
      checkOutput("write_issues", obsOp.size(), 1);
      if (obsOp.size() > 0) begin
         checkOutput("write_op", obsOp[0], 8'd87);
         checkOutput("write_addr", obsAddr[0], 16'h2002);
         checkOutput("write_wdata", obsWdata[0], 16'hBEEF);
      end

      $display("[TB] random traffic");
      fMode = 1; dMode = 1; latMode = 0;
      repeat (400) runCycle();
      fMode = 0; dMode = 0;
      runUntilIdle(100, "randomDrain");
      checkOutput("random_fetch_grants", fGrants > 10, 1);
      checkOutput("random_data_grants", dGrants > 10, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one multi-cycle memory port between two requesters: instruction fetch (read-only) and the data memory stage (read/write). The port uses the Stall/Done handshake of the codebase's cache memory system. Sits between fetch/memory stages and the unified memory. Fixed priority favours data, and a streak limit bounds fetch starvation. Per-requester stall/done and a timeout error are returned.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
MAX_STREAK, 4, consecutive data grants allowed while fetch waits, before fetch is forced
TIMEOUT, 64, cycles to wait for mem_done before error

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
f_rd  in  1  fetch read request; held until f_done
f_addr  in  ADDR_W  fetch address
f_stall  out  1  fetch must hold request
f_done  out  1  one-cycle pulse; f_rdata valid
f_rdata  out  DATA_W  fetch read data
d_rd  in  1  data read request; held until d_done
d_wr  in  1  data write request; held until d_done
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_stall  out  1  data stage must hold request
d_done  out  1  one-cycle pulse; d_rdata valid on reads
d_rdata  out  DATA_W  data read data
mem_rd  out  1  one-cycle read issue to memory
mem_wr  out  1  one-cycle write issue to memory
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_rdata  in  DATA_W  memory read data, valid with mem_done
mem_done  in  1  memory completion pulse
err  out  1  one-cycle pulse on timeout or illegal d_rd&d_wr

Behaviour:
- Reset: state=IDLE. All outputs 0: mem_rd, mem_wr, mem_addr, mem_wdata, f_done, d_done, f_rdata, d_rdata, err, streak.
- FSM states: IDLE, ISSUE_D, ISSUE_F, WAIT_D, WAIT_F.
- IDLE:
  - Sample requests and choose the winner.
  - d_rd&d_wr both high: err pulse next cycle; no issue; stay IDLE.
  - Winner is data if a data request is present, unless f_rd=1 and streak>=MAX_STREAK; then fetch wins.
  - On a grant, latch addr/wdata/op into mem_* registers. Go to ISSUE_D or ISSUE_F.
- ISSUE_x:
  - mem_rd or mem_wr high for exactly this one cycle.
  - Go to WAIT_x and clear the timeout counter.
- WAIT_x:
  - mem_done=1: pulse x_done the same cycle, with x_rdata=mem_rdata (combinational pass-through; registered copy held until next done); return to IDLE.
  - Timeout counter reaches TIMEOUT-1 without mem_done: pulse err and x_done (rdata=0); return to IDLE.
  - mem_done in the ISSUE cycle is ignored; the memory must not complete in 0 cycles.
- Streak counter:
  - Increments on each data grant while f_rd=1.
  - Clears on a fetch grant or when f_rd=0. Saturates at MAX_STREAK.
- Stalls, combinational:
  - f_stall = f_rd & ~f_done.
  - d_stall = (d_rd|d_wr) & ~d_done.
- Latency:
  - Uncontended minimum is request→issue 1 cycle, issue→done >=1 cycle.
  - Each transaction is followed by a 1-cycle IDLE bubble.
- Requesters must change or drop the request the cycle after done; a held request is treated as a new one.
- Request dropped mid-transaction: the transaction completes anyway; the done pulse is still generated and may be ignored.
- Async reset mid-transaction: immediate return to IDLE. The in-flight memory op is abandoned, and no done or err is produced.

Decomposition:
- Shared package holds the state enum (IDLE, ISSUE_D, ISSUE_F, WAIT_D, WAIT_F), the ADDR_W/DATA_W defaults, and the op encoding (OP_RD, OP_WR).
- One natural sub-module: arb_timeout_ctr. Clear/enable inputs, expired output, width $clog2(TIMEOUT).

Test Plan:
- Fetch alone, f_addr=0x0040, memory done 3 cycles after issue.
  → mem_rd 1 cycle with mem_addr=0x0040; f_done pulses with f_rdata=mem_rdata; f_stall high until then.
- d_rd at 0x1000 and f_rd at 0x0002 simultaneously.
  → data issued first, fetch issued after the d_done + bubble; d_stall and f_stall behave per formulas.
- d_wr held for 6 back-to-back transactions while f_rd is held.
  → fetch granted after 4 data grants (MAX_STREAK=4); streak cleared.
- mem_done never returns.
  → err and x_done pulse 64 cycles after issue; FSM back in IDLE; next request serviced normally.
- d_rd=d_wr=1.
  → err pulse; no mem_rd or mem_wr.
- rst asserted during WAIT_D.
  → all outputs 0 immediately; no d_done.
- d_wr with d_wdata=0xBEEF at 0x2002.
  → mem_wr=1 and mem_wdata=0xBEEF in the issue cycle.
